// File: rtl/coef_delay_bank_pkg.sv
// Shared constants, FSM encoding and address helper for the MCAC coefficient delay bank.
package coef_delay_bank_pkg;
  localparam int CHANNELS = 32;
  localparam int NCOEF    = 8;
  localparam int WIDTH    = 16;
  localparam int CHAN_W   = $clog2(CHANNELS);
  localparam int IDX_BITS = $clog2(NCOEF);
  localparam int DEPTH    = CHANNELS * NCOEF;
  localparam int ADDR_W   = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_CLR  = 2'd2
  } state_e;

  localparam logic [2:0] IDX_A1 = 3'd0;
  localparam logic [2:0] IDX_A2 = 3'd1;
  localparam logic [2:0] IDX_B1 = 3'd2;
  localparam logic [2:0] IDX_B2 = 3'd3;
  localparam logic [2:0] IDX_B3 = 3'd4;
  localparam logic [2:0] IDX_B4 = 3'd5;
  localparam logic [2:0] IDX_B5 = 3'd6;
  localparam logic [2:0] IDX_B6 = 3'd7;

  function automatic logic [ADDR_W-1:0] coef_addr(input logic [CHAN_W-1:0] chan,
                                                  input logic [IDX_BITS-1:0] idx);
    return {chan, idx};
  endfunction
endpackage

// File: rtl/coef_ram_1r1w.sv
// Coefficient storage: unreset array, synchronous write, registered read (read-before-write).
module coef_ram_1r1w
  import coef_delay_bank_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_d;
  logic [WIDTH-1:0] rdata_q;

  // Read data holds between reads; the array read sees the pre-write contents.
  always_comb begin
    if (re) begin
      rdata_d = mem_q[raddr];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Array write port; contents are zeroed by the sweep, not by reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read data register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/coef_delay_bank.sv
// Per-channel delay storage for the MCAC predictor coefficients, with power-up sweep and
// per-channel clear.
module coef_delay_bank
  import coef_delay_bank_pkg::*;
#(
  parameter int IDX_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scan_in0,
  input  logic              scan_in1,
  input  logic              scan_in2,
  input  logic              scan_in3,
  input  logic              scan_in4,
  input  logic              scan_enable,
  input  logic              test_mode,
  output logic              scan_out0,
  output logic              scan_out1,
  output logic              scan_out2,
  output logic              scan_out3,
  output logic              scan_out4,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [CHAN_W-1:0] wr_chan,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WIDTH-1:0]  AnR,
  input  logic              rd_req,
  output logic              rd_ready,
  input  logic [CHAN_W-1:0] rd_chan,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [WIDTH-1:0]  AnD,
  input  logic              clr_req,
  input  logic [CHAN_W-1:0] clr_chan,
  output logic              busy
);
  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [CHAN_W-1:0]   clr_chan_q, clr_chan_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_zero_q, rd_zero_d;
  logic                wr_idx_ok, rd_idx_ok;
  logic                ram_we, ram_re;
  logic [ADDR_W-1:0]   ram_waddr, ram_raddr;
  logic [WIDTH-1:0]    ram_wdata, ram_rdata;
  logic                scan_unused;

  assign scan_unused = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4, scan_enable, test_mode};
  assign scan_out0 = 1'b0;
  assign scan_out1 = 1'b0;
  assign scan_out2 = 1'b0;
  assign scan_out3 = 1'b0;
  assign scan_out4 = 1'b0;

  assign wr_idx_ok = (int'(wr_idx) < NCOEF);
  assign rd_idx_ok = (int'(rd_idx) < NCOEF);
  assign ram_raddr = coef_addr(rd_chan, rd_idx[IDX_BITS-1:0]);

  // Sequencing of sweep/clear and arbitration of the single write port.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    clr_chan_d = clr_chan_q;
    rd_valid_d = 1'b0;
    rd_zero_d  = rd_zero_q;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_waddr  = ptr_q;
    ram_wdata  = '0;
    case (state_q)
      ST_INIT: begin
        ram_we = 1'b1;
        if (ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        ram_we     = wr_valid & wr_idx_ok;
        ram_waddr  = coef_addr(wr_chan, wr_idx[IDX_BITS-1:0]);
        ram_wdata  = AnR;
        ram_re     = rd_req & rd_idx_ok;
        rd_valid_d = rd_req;
        if (rd_req) begin
          rd_zero_d = ~rd_idx_ok;
        end else begin
          rd_zero_d = rd_zero_q;
        end
        // Same-cycle write/read still complete; the clear then overwrites clr_chan.
        if (clr_req) begin
          state_d    = ST_CLR;
          clr_chan_d = clr_chan;
          ptr_d      = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLR: begin
        ram_we    = 1'b1;
        ram_waddr = coef_addr(clr_chan_q, ptr_q[IDX_BITS-1:0]);
        if (ptr_q[IDX_BITS-1:0] == IDX_BITS'(NCOEF - 1)) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = ST_INIT;
        ptr_d   = '0;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_INIT;
      ptr_q      <= '0;
      clr_chan_q <= '0;
      rd_valid_q <= 1'b0;
      rd_zero_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      clr_chan_q <= clr_chan_d;
      rd_valid_q <= rd_valid_d;
      rd_zero_q  <= rd_zero_d;
    end
  end

  coef_ram_1r1w u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign wr_ready = (state_q == ST_IDLE);
  assign rd_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign rd_valid = rd_valid_q;
  assign AnD      = rd_zero_q ? '0 : ram_rdata;
endmodule

// File: tb/tb_coef_delay_bank.sv
// Randomized and directed checks of coef_delay_bank against an array-based reference model.
module tb_coef_delay_bank;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_valid = 1'b0, rd_req = 1'b0, clr_req = 1'b0;
  logic [4:0]  wr_chan = '0, rd_chan = '0, clr_chan = '0;
  logic [3:0]  wr_idx = '0, rd_idx = '0;
  logic [15:0] AnR = '0;
  logic        wr_ready, rd_ready, rd_valid, busy;
  logic [15:0] AnD;
  logic        so0, so1, so2, so3, so4;

  int          total = 0;
  int          bad = 0;
  logic [15:0] mem_m [256];
  int          busy_left = 0;
  logic [15:0] last_and = 16'h0000;

  always #5 clk = ~clk;

  coef_delay_bank #(.IDX_W(4)) dut (
    .clk(clk), .reset(reset),
    .scan_in0(1'b0), .scan_in1(1'b0), .scan_in2(1'b0), .scan_in3(1'b0), .scan_in4(1'b0),
    .scan_enable(1'b0), .test_mode(1'b0),
    .scan_out0(so0), .scan_out1(so1), .scan_out2(so2), .scan_out3(so3), .scan_out4(so4),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_chan(wr_chan), .wr_idx(wr_idx), .AnR(AnR),
    .rd_req(rd_req), .rd_ready(rd_ready), .rd_chan(rd_chan), .rd_idx(rd_idx),
    .rd_valid(rd_valid), .AnD(AnD),
    .clr_req(clr_req), .clr_chan(clr_chan), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    foreach (mem_m[k]) mem_m[k] = 16'h0000;
    busy_left = 256;
    last_and  = 16'h0000;
    chk("rst_busy", busy, 1'b1);
    chk("rst_wr_ready", wr_ready, 1'b0);
    chk("rst_rd_ready", rd_ready, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_AnD", AnD, 16'h0000);
    chk("rst_scan", {so0, so1, so2, so3, so4}, 5'd0);
  endtask

  // One clock cycle of stimulus; the model decides acceptance from its own busy countdown.
  task automatic cyc(input logic wv, input logic [4:0] wc, input logic [3:0] wi, input logic [15:0] wd,
                     input logic rq, input logic [4:0] rc, input logic [3:0] ri,
                     input logic cq, input logic [4:0] cc);
    logic        idle;
    logic        rd_acc;
    logic [15:0] exp_rd;
    wr_valid = wv; wr_chan = wc; wr_idx = wi; AnR = wd;
    rd_req = rq; rd_chan = rc; rd_idx = ri;
    clr_req = cq; clr_chan = cc;
    idle   = (busy_left == 0);
    rd_acc = rq && idle;
    if (rd_acc) exp_rd = (ri < 4'd8) ? mem_m[int'(rc) * 8 + int'(ri)] : 16'h0000;
    else        exp_rd = last_and;
    if (wv && idle && wi < 4'd8) mem_m[int'(wc) * 8 + int'(wi)] = wd;
    if (busy_left > 0) busy_left--;
    if (cq && idle) begin
      busy_left = 8;
      for (int k = 0; k < 8; k++) mem_m[int'(cc) * 8 + k] = 16'h0000;
    end
    @(posedge clk); #1;
    wr_valid = 1'b0; rd_req = 1'b0; clr_req = 1'b0;
    chk("rd_valid", rd_valid, rd_acc);
    chk("AnD", AnD, exp_rd);
    last_and = exp_rd;
    chk("busy", busy, busy_left != 0);
    chk("wr_ready", wr_ready, busy_left == 0);
    chk("rd_ready", rd_ready, busy_left == 0);
  endtask

  task automatic wr(input logic [4:0] c, input logic [3:0] i, input logic [15:0] d);
    cyc(1'b1, c, i, d, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0);
  endtask

  task automatic rd(input logic [4:0] c, input logic [3:0] i);
    cyc(1'b0, 5'd0, 4'd0, 16'h0000, 1'b1, c, i, 1'b0, 5'd0);
  endtask

  task automatic idle_n(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 5'd0, 4'd0, 16'h0000, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0);
  endtask

  initial begin
    int busy_cnt;
    do_reset();
    idle_n(256);
    chk("init_done_busy", busy, 1'b0);
    for (int a = 0; a < 256; a++) rd(5'(a / 8), 4'(a % 8));

    wr(5'd5, 4'd2, 16'h1234);
    rd(5'd5, 4'd2);
    chk("ch5_idx2", AnD, 16'h1234);

    wr(5'd3, 4'd0, 16'h0001);
    cyc(1'b1, 5'd3, 4'd0, 16'hBEEF, 1'b1, 5'd3, 4'd0, 1'b0, 5'd0);
    chk("rbw_old", AnD, 16'h0001);
    rd(5'd3, 4'd0);
    chk("rbw_new", AnD, 16'hBEEF);

    for (int i = 0; i < 8; i++) wr(5'd7, 4'(i), 16'hFFFF);
    for (int i = 0; i < 8; i++) wr(5'd6, 4'(i), 16'(16'h1111 * (i + 1)));
    cyc(1'b0, 5'd0, 4'd0, 16'h0000, 1'b0, 5'd0, 4'd0, 1'b1, 5'd7);
    busy_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (busy) busy_cnt++;
      idle_n(1);
    end
    chk("clr_busy_cycles", busy_cnt, 8);
    for (int i = 0; i < 8; i++) rd(5'd7, 4'(i));
    for (int i = 0; i < 8; i++) rd(5'd6, 4'(i));
    chk("ch6_idx7_kept", AnD, 16'h8888);

    wr(5'd0, 4'd7, 16'h8000);
    rd(5'd0, 4'd7);
    chk("most_neg", AnD, 16'h8000);

    wr(5'd4, 4'd8, 16'h5A5A);
    rd(5'd4, 4'd8);
    chk("idx8_zero", AnD, 16'h0000);
    for (int i = 0; i < 8; i++) rd(5'd4, 4'(i));
    for (int i = 0; i < 8; i++) rd(5'd5, 4'(i));

    wr(5'd9, 4'd1, 16'h1111);
    cyc(1'b1, 5'd9, 4'd1, 16'hAAAA, 1'b1, 5'd9, 4'd1, 1'b1, 5'd9);
    chk("clr_same_cycle_rd", AnD, 16'h1111);
    idle_n(8);
    rd(5'd9, 4'd1);
    chk("clr_overwrites_wr", AnD, 16'h0000);

    for (int n = 0; n < 600; n++) begin
      cyc(1'($urandom), 5'($urandom), 4'($urandom_range(0, 9)), 16'($urandom),
          1'($urandom), 5'($urandom), 4'($urandom_range(0, 9)),
          ($urandom_range(0, 39) == 0), 5'($urandom));
    end

    do_reset();
    idle_n(100);
    do_reset();
    idle_n(256);
    for (int n = 0; n < 40; n++) rd(5'($urandom), 4'($urandom_range(0, 7)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
